// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access pipeline stage. It takes one ALU-stage result at a time and
// issues at most one load or store to the data cache. Load data is aligned and
// then sign- or zero-extended. Store data is shifted into byte lanes, with
// matching byte strobes. Results go to writeback through a valid/ready output
// register. Non-memory ops pass through in one cycle.
//
// Optional feature: define MM_MISALIGN_TRAP_EN to make a misaligned access
// fault. When the macro is undefined, a misaligned offset is aligned down
// instead.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   in_*              upstream op (valid/ready); in_op = {mem, store, unsigned, log2 size}
//   dc_req_*          data-cache request (valid/ready), word-aligned address
//   dc_resp_*         data-cache response (load data or store ack)
//   out_*             registered writeback result (valid/ready)
module mem_access_stage #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int REGNO_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_op,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [REGNO_WIDTH-1:0]    in_rd_regno,
  input  logic                      in_update_rd,
  output logic                      dc_req_valid,
  input  logic                      dc_req_ready,
  output logic [ADDR_WIDTH-1:0]     dc_req_addr,
  output logic                      dc_req_write,
  output logic [DATA_WIDTH-1:0]     dc_req_wdata,
  output logic [DATA_WIDTH/8-1:0]   dc_req_wstrb,
  input  logic                      dc_resp_valid,
  input  logic [DATA_WIDTH-1:0]     dc_resp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [ADDR_WIDTH-1:0]     out_alu_result,
  output logic [REGNO_WIDTH-1:0]    out_rd_regno,
  output logic                      out_update_rd,
  output logic                      out_load,
  output logic                      out_fault
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;

  function automatic logic [3:0] nbytes_f(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Keep the low nbytes of the store value, then move them to the lane at off.
  function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [DATA_WIDTH-1:0] data,
                                                       input logic [1:0] size,
                                                       input logic [OFF_W-1:0] off);
    logic [DATA_WIDTH-1:0] masked;
    int nb;
    nb = int'(nbytes_f(size));
    for (int i = 0; i < DATA_WIDTH; i++) masked[i] = (i < 8 * nb) ? data[i] : 1'b0;
    return masked << {off, 3'b000};
  endfunction

  function automatic logic [STRB_W-1:0] lane_wstrb(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] s;
    int nb;
    nb = int'(nbytes_f(size));
    for (int i = 0; i < STRB_W; i++) s[i] = (i < nb);
    return s << off;
  endfunction

  // Shift the addressed bytes down to bit 0, then extend above nbytes.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] resp,
                                                        input logic [1:0] size,
                                                        input logic [OFF_W-1:0] off,
                                                        input logic uns);
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] r;
    logic msb;
    int nb;
    nb  = int'(nbytes_f(size));
    sh  = resp >> {off, 3'b000};
    msb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) if (i == 8 * nb - 1) msb = sh[i];
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = (i < 8 * nb) ? sh[i] : (uns ? 1'b0 : msb);
    return r;
  endfunction

  logic [OFF_W-1:0] off_raw;
  logic [OFF_W-1:0] size_mask;
  logic [OFF_W-1:0] off_use;
  logic             illegal;
  logic             fault;
  logic             accept;

  assign off_raw   = in_addr[OFF_W-1:0];
  assign size_mask = OFF_W'(nbytes_f(in_op[1:0]) - 4'd1);
  assign illegal   = nbytes_f(in_op[1:0]) > 4'(STRB_W);
`ifdef MM_MISALIGN_TRAP_EN
  assign off_use   = off_raw;
  assign fault     = in_op[4] && (illegal || ((off_raw & size_mask) != '0));
`else
  // Misaligned accesses are aligned down to the size boundary.
  assign off_use   = off_raw & ~size_mask;
  assign fault     = in_op[4] && illegal;
`endif

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Stage p1: op context held while the cache access is in flight
  logic [ADDR_WIDTH-1:0]  alu_p1;
  logic [REGNO_WIDTH-1:0] rd_p1;
  logic                   upd_p1;
  logic                   store_p1;
  logic                   uns_p1;
  logic [1:0]             size_p1;
  logic [OFF_W-1:0]       off_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      alu_p1   <= in_addr;
      rd_p1    <= in_rd_regno;
      upd_p1   <= in_update_rd;
      store_p1 <= in_op[3];
      uns_p1   <= in_op[2];
      size_p1  <= in_op[1:0];
      off_p1   <= off_use;
    end
  end

  // Stage p2: request FSM and writeback output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      dc_req_valid   <= 1'b0;
      dc_req_addr    <= '0;
      dc_req_write   <= 1'b0;
      dc_req_wdata   <= '0;
      dc_req_wstrb   <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_alu_result <= '0;
      out_rd_regno   <= '0;
      out_update_rd  <= 1'b0;
      out_load       <= 1'b0;
      out_fault      <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!in_op[4] || fault) begin
              out_valid      <= 1'b1;
              out_data       <= '0;
              out_alu_result <= in_addr;
              out_rd_regno   <= in_rd_regno;
              out_update_rd  <= in_update_rd && !fault;
              out_load       <= in_op[4] && !in_op[3];
              out_fault      <= fault;
            end else begin
              state        <= REQ;
              dc_req_valid <= 1'b1;
              dc_req_addr  <= {in_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
              dc_req_write <= in_op[3];
              dc_req_wdata <= in_op[3] ? lane_wdata(in_store_data, in_op[1:0], off_use) : '0;
              dc_req_wstrb <= in_op[3] ? lane_wstrb(in_op[1:0], off_use) : '0;
            end
          end
        end
        REQ: begin
          if (dc_req_ready) begin
            state        <= WAIT;
            dc_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (dc_resp_valid) begin
            state          <= IDLE;
            out_valid      <= 1'b1;
            out_data       <= store_p1 ? '0 : load_extend(dc_resp_data, size_p1, off_p1, uns_p1);
            out_alu_result <= alu_p1;
            out_rd_regno   <= rd_p1;
            out_update_rd  <= upd_p1;
            out_load       <= !store_p1;
            out_fault      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [63:0] in_addr;
  logic [63:0] in_store_data;
  logic [4:0]  in_rd_regno;
  logic        in_update_rd;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [63:0] dc_req_addr;
  logic        dc_req_write;
  logic [63:0] dc_req_wdata;
  logic [7:0]  dc_req_wstrb;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [63:0] out_alu_result;
  logic [4:0]  out_rd_regno;
  logic        out_update_rd;
  logic        out_load;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_rd_regno(in_rd_regno), .in_update_rd(in_update_rd),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_write(dc_req_write), .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_alu_result(out_alu_result), .out_rd_regno(out_rd_regno),
    .out_update_rd(out_update_rd), .out_load(out_load), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_addr = '0; in_store_data = '0;
    in_rd_regno = '0; in_update_rd = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    dc_resp_data = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", dc_req_valid); end
    checks++; if (out_data !== 64'h0 || out_alu_result !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h/%h expected 0/0", out_data, out_alu_result); end
    checks++; if (dc_req_wstrb !== 8'h0 || dc_req_addr !== 64'h0) begin errors++; $display("FAIL reset_req_fields: got %h/%h expected 0/0", dc_req_wstrb, dc_req_addr); end
    tick();
  endtask

  task automatic test_load(input logic [4:0] op, input logic [63:0] addr, input logic [63:0] exp_addr,
                           input logic [63:0] resp, input logic [63:0] exp_data, input string name);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_rd_regno = 5'd3; in_update_rd = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b0) begin errors++; $display("FAIL %s_req: got valid=%b write=%b expected 1/0", name, dc_req_valid, dc_req_write); end
    checks++; if (dc_req_addr !== exp_addr) begin errors++; $display("FAIL %s_req_addr: got %h expected %h", name, dc_req_addr, exp_addr); end
    checks++; if (dc_req_wstrb !== 8'h0 || dc_req_wdata !== 64'h0) begin errors++; $display("FAIL %s_req_lanes: got %h/%h expected 0/0", name, dc_req_wstrb, dc_req_wdata); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b expected 0", name, in_ready); end
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_data = resp;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || dc_req_valid !== 1'b0) begin errors++; $display("FAIL %s_wait: got out_valid=%b req_valid=%b expected 0/0", name, out_valid, dc_req_valid); end
    tick();
    dc_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_load !== 1'b1 || out_fault !== 1'b0) begin errors++; $display("FAIL %s_out_flags: got v=%b l=%b f=%b expected 1/1/0", name, out_valid, out_load, out_fault); end
    checks++; if (out_data !== exp_data) begin errors++; $display("FAIL %s_out_data: got %h expected %h", name, out_data, exp_data); end
    checks++; if (out_alu_result !== addr || out_rd_regno !== 5'd3 || out_update_rd !== 1'b1) begin errors++; $display("FAIL %s_passthru: got %h/%0d/%b expected %h/3/1", name, out_alu_result, out_rd_regno, out_update_rd, addr); end
    tick();
  endtask

  task automatic test_store_half();
    in_valid = 1'b1; in_op = 5'b11001; in_addr = 64'h2006; in_store_data = 64'hABCD1234;
    in_rd_regno = 5'd0; in_update_rd = 1'b0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b1) begin errors++; $display("FAIL sh_req: got valid=%b write=%b expected 1/1", dc_req_valid, dc_req_write); end
    checks++; if (dc_req_wstrb !== 8'hC0) begin errors++; $display("FAIL sh_wstrb: got %h expected c0", dc_req_wstrb); end
    checks++; if (dc_req_wdata !== 64'h1234000000000000) begin errors++; $display("FAIL sh_wdata: got %h expected 1234000000000000", dc_req_wdata); end
    checks++; if (dc_req_addr !== 64'h2000) begin errors++; $display("FAIL sh_addr: got %h expected 2000", dc_req_addr); end
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dc_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h0 || out_load !== 1'b0) begin errors++; $display("FAIL sh_out: got v=%b d=%h l=%b expected 1/0/0", out_valid, out_data, out_load); end
    tick();
  endtask

  task automatic test_misaligned_lw();
`ifdef MM_MISALIGN_TRAP_EN
    in_valid = 1'b1; in_op = 5'b10010; in_addr = 64'h1002; in_rd_regno = 5'd9; in_update_rd = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_update_rd !== 1'b0) begin errors++; $display("FAIL lw_mis_fault: got v=%b f=%b u=%b expected 1/1/0", out_valid, out_fault, out_update_rd); end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL lw_mis_noreq: got %b expected 0", dc_req_valid); end
    tick();
    @(negedge clk);
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL lw_mis_noreq2: got %b expected 0", dc_req_valid); end
    tick();
`else
    test_load(5'b10010, 64'h1002, 64'h1000, 64'h11223344_55667788, 64'h55667788, "lw_mis");
`endif
  endtask

  task automatic test_req_stall();
    in_valid = 1'b1; in_op = 5'b11010; in_addr = 64'h3004; in_store_data = 64'hDEADBEEF;
    in_rd_regno = 5'd0; in_update_rd = 1'b0; dc_req_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (dc_req_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_valid_%0d: got valid=%b in_ready=%b expected 1/0", i, dc_req_valid, in_ready); end
      checks++; if (dc_req_addr !== 64'h3000 || dc_req_wstrb !== 8'hF0 || dc_req_wdata !== 64'hDEADBEEF_00000000) begin errors++; $display("FAIL stall_fields_%0d: got %h/%h/%h expected 3000/f0/deadbeef00000000", i, dc_req_addr, dc_req_wstrb, dc_req_wdata); end
      tick();
    end
    @(negedge clk);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
    tick();
    dc_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h0) begin errors++; $display("FAIL stall_done: got v=%b d=%h expected 1/0", out_valid, out_data); end
    tick();
  endtask

  task automatic test_out_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 5'b00000; in_addr = 64'h55; in_rd_regno = 5'd7; in_update_rd = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", in_ready); end
    tick();
    in_addr = 64'h66; in_rd_regno = 5'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_alu_result !== 64'h55 || out_rd_regno !== 5'd7 || out_update_rd !== 1'b1 || out_data !== 64'h0) begin errors++; $display("FAIL bp_hold_%0d: got v=%b a=%h r=%0d u=%b d=%h expected 1/55/7/1/0", i, out_valid, out_alu_result, out_rd_regno, out_update_rd, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0", i, in_ready); end
      if (i == 2) begin
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: got %b expected 1", in_ready); end
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_alu_result !== 64'h66 || out_rd_regno !== 5'd8) begin errors++; $display("FAIL bp_refill: got v=%b a=%h r=%0d expected 1/66/8", out_valid, out_alu_result, out_rd_regno); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 5'b00000; in_addr = 64'hA0 + 64'(i); in_rd_regno = 5'(i + 1); in_update_rd = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready); end
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1 || out_alu_result !== 64'hA0 + 64'(i - 1)) begin errors++; $display("FAIL b2b_out_%0d: got v=%b a=%h expected 1/%h", i, out_valid, out_alu_result, 64'hA0 + 64'(i - 1)); end
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_alu_result !== 64'hA2 || out_rd_regno !== 5'd3) begin errors++; $display("FAIL b2b_last: got v=%b a=%h r=%0d expected 1/a2/3", out_valid, out_alu_result, out_rd_regno); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    in_valid = 1'b1; in_op = 5'b10000; in_addr = 64'h1000; in_rd_regno = 5'd4; in_update_rd = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || dc_req_valid !== 1'b0) begin errors++; $display("FAIL rstw_ctrl: got in_ready=%b v=%b req=%b expected 1/0/0", in_ready, out_valid, dc_req_valid); end
    checks++; if (out_alu_result !== 64'h0 || dc_req_addr !== 64'h0 || out_rd_regno !== 5'd0 || out_load !== 1'b0) begin errors++; $display("FAIL rstw_zero: got a=%h ra=%h r=%0d l=%b expected 0", out_alu_result, dc_req_addr, out_rd_regno, out_load); end
    dc_resp_valid = 1'b1; dc_resp_data = 64'h12;
    tick();
    dc_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstw_stray_resp: got %b expected 0", out_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load(5'b10000, 64'h1003, 64'h1000, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, "lb");
    test_load(5'b10100, 64'h1003, 64'h1000, 64'h00000000_80000000, 64'h80, "lbu");
    test_store_half();
    test_misaligned_lw();
    test_req_stall();
    test_out_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage; successor to the fixed-width MM stage. It accepts one ALU-stage result at a time and issues at most one load or store to the data cache. Load data is aligned and sign- or zero-extended; store data is shifted into byte lanes with byte strobes. Results go to writeback through a valid/ready output register. Non-memory ops pass through in one cycle.

## Interface
- DATA_WIDTH, 64, register/cache word width; legal values 32 or 64
- ADDR_WIDTH, 64, address width
- REGNO_WIDTH, 5, destination register number width
- Clock clk; reset reset, synchronous, active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  upstream has an op
- in_ready  out  1  stage accepts the op this cycle
- in_op  in  5  [4] mem access, [3] store, [2] unsigned load, [1:0] log2 size (0=b, 1=h, 2=w, 3=d)
- in_addr  in  ADDR_WIDTH  effective address or ALU result
- in_store_data  in  DATA_WIDTH  rs2 value
- in_rd_regno  in  REGNO_WIDTH  destination register
- in_update_rd  in  1  op writes rd
- dc_req_valid  out  1  cache request valid
- dc_req_ready  in  1  cache accepts request
- dc_req_addr  out  ADDR_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits zero)
- dc_req_write  out  1  1 = store
- dc_req_wdata  out  DATA_WIDTH  lane-shifted store data
- dc_req_wstrb  out  DATA_WIDTH/8  byte enables
- dc_resp_valid  in  1  load data returned or store acknowledged
- dc_resp_data  in  DATA_WIDTH  cache word
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_data  out  DATA_WIDTH  extended load data; 0 for non-loads
- out_alu_result  out  ADDR_WIDTH  in_addr passthrough
- out_rd_regno  out  REGNO_WIDTH  passthrough
- out_update_rd  out  1  passthrough; forced 0 on fault
- out_load  out  1  op was a load
- out_fault  out  1  access rejected (illegal size or misaligned)

## Operation
- FSM states: IDLE, REQ, WAIT. Reset gives IDLE. All outputs are 0 on reset.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept (in_valid && in_ready). Latch op, addr, store data, regno, update_rd.
  - Non-memory op (in_op[4]=0): output register loaded next edge with out_data=0.
  - Fault op: output register loaded next edge with out_fault=1 and out_update_rd=0. No cache request.
  - Memory op: go to REQ.
- Illegal size (2^size > DATA_WIDTH/8) always faults.
- offset = addr[log2(DATA_WIDTH/8)-1:0]; nbytes = 2^size.
- Store lanes:
  - wdata = (store_data masked to nbytes) << 8*offset
  - wstrb = ((1<<nbytes)-1) << offset
  - Load requests drive wdata=0, wstrb=0.
- REQ: dc_req_valid=1. Request fields are held stable until dc_req_ready. On handshake, go to WAIT.
- WAIT: dc_resp_valid is sampled only here. On it, go to IDLE and load the output register.
  - Load: out_data = (resp >> 8*offset), truncated to nbytes, then sign-extended (in_op[2]=0) or zero-extended.
  - Store: out_data=0.
- dc_resp_valid outside WAIT is ignored.
- Output register holds all out_* stable while out_valid && !out_ready. It clears out_valid on out_ready when no new result is loaded.
- Reset mid-transaction abandons the access. The cache owner flushes any request it already accepted.

## Timing
- Non-memory/fault: accepted at edge N, out_valid at N+1. Back-to-back throughput is 1/cycle when out_ready=1.
- Memory: accepted at N, dc_req_valid high from N+1. With dc_req_ready at N+1 and dc_resp_valid at M>=N+2, out_valid is high from M+1.
- Minimum memory latency is 3 cycles.
- in_ready is low from acceptance of a memory op until the result is loaded.
- The output register drains and refills in the same cycle when out_ready=1.

## Configuration
- MM_MISALIGN_TRAP_EN defined: offset % nbytes != 0 sets out_fault=1, no cache access, one-cycle result.
- MM_MISALIGN_TRAP_EN undefined: misaligned offset is aligned down (low size bits cleared) before lane/strobe/extract computation. out_fault only for illegal size. out_alu_result still carries the original address.

## Test plan
- lb addr 0x1003, resp 0x00000000_80000000 -> out_data 0xFFFFFFFF_FFFFFF80. Same with lbu -> 0x80.
- sh addr 0x2006, store_data 0xABCD1234 -> dc_req_wstrb 0xC0, dc_req_wdata 0x1234000000000000, dc_req_write=1. Resp ack -> out_data 0, out_load 0.
- lw addr 0x1002:
  - Macro defined: out_fault=1, out_update_rd=0, dc_req_valid never high.
  - Macro undefined: dc_req_addr 0x1000, resp 0x11223344_55667788 -> out_data 0x55667788.
- dc_req_ready low 4 cycles: dc_req_valid, addr, wdata, wstrb unchanged each cycle; in_ready=0 throughout.
- out_ready low 3 cycles after a non-memory op: out_* held, in_ready=0. The 4th cycle drains and accepts the next op.
- Reset asserted in WAIT: next cycle state IDLE, all outputs 0, in_ready=1. A dc_resp_valid one cycle later produces no out_valid.
